// File: rtl/fft_pkg.sv
// Shared widths and the bit-reversal helper for the FFT output reorder buffer.
package fft_pkg;

    localparam int SAMPLE_W  = 34;
    localparam int LANES     = 4;
    localparam int FRAME_LEN = 16;
    localparam int WORD_W    = 136;

    // Reverse a 4-bit index. Frames arrive in bit-reversed order, so this maps
    // an arrival position to its natural bin, and a natural bin back to its position.
    function automatic logic [3:0] bitrev4(input logic [3:0] p);
        return {p[0], p[1], p[2], p[3]};
    endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Input word stream and output sample stream of the FFT output reorder buffer.
interface fft_out_reorder_if
    import fft_pkg::*;
();
    logic [WORD_W-1:0]   data_in;
    logic                in_valid;
    logic                in_ready;
    logic [SAMPLE_W-1:0] data_out;
    logic [3:0]          out_index;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    // master: the surrounding FFT datapath / consumer
    modport master (
        output data_in, in_valid, out_ready,
        input  in_ready, data_out, out_index, out_valid, out_last
    );

    // slave: the reorder buffer itself
    modport slave (
        input  data_in, in_valid, out_ready,
        output in_ready, data_out, out_index, out_valid, out_last
    );
endinterface

// File: rtl/fft_out_reorder_bank.sv
// One 16-sample frame buffer: a full input word (4 lanes) is written per cycle,
// and a single sample is read combinationally. Storage has no reset; the
// controller never exposes a bank unless its full flag is set.
module reorder_bank
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                i_we,
    input  logic [1:0]          i_waddr_word,
    input  logic [WORD_W-1:0]   i_wdata,
    input  logic [3:0]          i_raddr,
    output logic [SAMPLE_W-1:0] o_rdata
);
    logic [SAMPLE_W-1:0] r_mem [FRAME_LEN];

    // Store all four lanes of the accepted word at addresses 4w..4w+3.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < LANES; l++) begin
                r_mem[{i_waddr_word, l[1:0]}] <= i_wdata[l*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: collects bit-reversed FFT output words into one
// bank while the other bank is drained one sample per transfer in natural order.
module fft_out_reorder
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    fft_out_reorder_if.slave bus
);
    logic [1:0]          r_full;
    logic                r_wb;
    logic                r_rb;
    logic [1:0]          r_wcnt;
    logic [3:0]          r_rcnt;

    logic [1:0]          w_full_nxt;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_out_valid;
    logic                w_fill_done;
    logic                w_drain_done;
    logic [1:0]          w_we;
    logic [3:0]          w_raddr;
    logic [SAMPLE_W-1:0] w_rdata [2];

    assign bus.in_ready = !r_full[r_wb];
    assign w_in_xfer    = bus.in_valid && !r_full[r_wb];
    assign w_out_valid  = r_full[r_rb];
    assign w_out_xfer   = w_out_valid && bus.out_ready;
    assign w_fill_done  = w_in_xfer && (r_wcnt == 2'd3);
    assign w_drain_done = w_out_xfer && (r_rcnt == 4'd15);
    assign w_we         = {w_in_xfer && r_wb, w_in_xfer && !r_wb};
    assign w_raddr      = bitrev4(r_rcnt);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank u_bank (
            .clk          (clk),
            .i_we         (w_we[b]),
            .i_waddr_word (r_wcnt),
            .i_wdata      (bus.data_in),
            .i_raddr      (w_raddr),
            .o_rdata      (w_rdata[b])
        );
    end

    assign bus.out_valid = w_out_valid;
    assign bus.data_out  = w_out_valid ? w_rdata[r_rb] : '0;
    assign bus.out_index = r_rcnt;
    assign bus.out_last  = w_out_valid && (r_rcnt == 4'd15);

    // Fill-complete and drain-complete always target different banks, so both
    // flag updates can land on the same edge without losing a frame.
    always_comb begin
        w_full_nxt = r_full;
        if (w_fill_done) begin
            w_full_nxt[r_wb] = 1'b1;
        end
        if (w_drain_done) begin
            w_full_nxt[r_rb] = 1'b0;
        end
    end

    // Pointer, counter and full-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_wcnt <= 2'd0;
            r_rcnt <= 4'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_xfer) begin
                r_wcnt <= r_wcnt + 2'd1;
            end
            if (w_fill_done) begin
                r_wb <= !r_wb;
            end
            if (w_out_xfer) begin
                r_rcnt <= r_rcnt + 4'd1;
            end
            if (w_drain_done) begin
                r_rb <= !r_rb;
            end
        end
    end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL: data_in  input  136  four complex samples; lane L = bits[34L+33:34L]; each sample {re[16:0], im[16:0]}.
REQ-004 SHALL: in_valid  input  1  data_in holds a valid word.
REQ-005 SHALL: in_ready  output  1  block accepts data_in this cycle.
REQ-006 SHALL: data_out  output  34  one complex sample in natural frequency order.
REQ-007 SHALL: out_index  output  4  natural bin index k of data_out.
REQ-008 SHALL: out_valid  output  1  data_out/out_index/out_last valid.
REQ-009 SHALL: out_ready  input  1  consumer accepts data_out this cycle.
REQ-010 SHALL: out_last  output  1  high with k=15 (final sample of frame).

Function
REQ-011 SHALL: frame = 16 samples = 4 input words; word w (0..3), lane L gives arrival position p = 4w+L.
REQ-012 SHALL: input is bit-reversed order; natural bin k = bitrev4(p) (p[3:0] reversed).
REQ-013 SHALL: input transfer occurs only when in_valid && in_ready; in_valid without in_ready leaves all state unchanged.
REQ-014 SHALL: two 16x34 banks (ping-pong); write bank pointer wb, read bank pointer rb, per-bank full flag.
REQ-015 SHALL: in_ready = !full[wb]; accepted word w stored in bank wb at addresses 4w..4w+3; 2-bit word counter wcnt increments per transfer.
REQ-016 SHALL: on transfer with wcnt==3: full[wb] set, wb toggles, wcnt wraps to 0, all in the same edge.
REQ-017 SHALL: out_valid = full[rb]; data_out = bank rb at address bitrev4(rcnt); out_index = rcnt; out_last = out_valid && rcnt==15.
REQ-018 SHALL: output transfer occurs when out_valid && out_ready; rcnt (4-bit) increments per transfer; data_out held stable while out_valid && !out_ready.
REQ-019 SHALL: on output transfer with rcnt==15: full[rb] cleared, rb toggles, rcnt wraps to 0.
REQ-020 SHALL: latency: out_valid rises the cycle after 4th word of a frame is accepted (bank previously idle).
REQ-021 SHALL: simultaneous fill-complete of one bank and drain-complete of the other both take effect in the same edge, no lost frame.
REQ-022 SHALL: both banks full -> in_ready low until the drain of bank rb completes; in_ready rises in the cycle after the final output transfer.
REQ-023 SHALL: data_out = 0 whenever out_valid is low.
REQ-024 SHALL: sustained throughput: one frame per 16 cycles with out_ready held high; in_valid may be asserted continuously.

Reset
REQ-025 SHALL: rst_n low asynchronously clears full[0], full[1], wb, rb, wcnt, rcnt; outputs in_ready=1, out_valid=0, out_last=0, out_index=0, data_out=0.
REQ-026 SHALL: reset mid-frame discards partial and buffered frames; first word after reset release is word 0 of a new frame.
REQ-027 SHALL: bank storage is not reset; contents are never observable while the corresponding full flag is clear.

Structure
REQ-028 SHALL: shared package fft_pkg holds SAMPLE_W=34, LANES=4, FRAME_LEN=16, WORD_W=136, and function bitrev4.
REQ-029 SHALL: one sub-module reorder_bank (16x34 storage, 4-lane aligned write port, 1-sample async read port), instantiated twice.
REQ-030 SHALL: control (pointers, flags, counters) resides in fft_out_reorder; no other sub-modules.

Verification
REQ-031 SHALL: reset, then one frame with sample value = p (re=p, im=0), out_ready=1 -> outputs k=0..15 with re=bitrev4(k): 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_last only at k=15.
REQ-032 SHALL: out_ready=0 for 40 cycles, in_valid=1 continuously -> exactly 8 words accepted, in_ready low from the 9th cycle, data_out stable at k=0 of frame 1.
REQ-033 SHALL: continuous in_valid/out_ready, 10 frames -> 160 samples with no gaps after first out_valid, frame order preserved.
REQ-034 SHALL: out_ready toggled 1010... during drain -> each sample presented until accepted, no duplicates/skips, total 32 cycles per frame.
REQ-035 SHALL: rst_n pulsed low after 2 words of frame 0 and mid-drain of frame 1 -> outputs go to reset values immediately; next 4 words form a clean frame output in correct order.
REQ-036 SHALL: in_valid deasserted between words (gaps of 0..3 cycles) -> frame assembled correctly, no spurious transfers.
